// File: rtl/intc_prio_arbiter.sv
// intc_prio_arbiter
// Sequential priority arbiter for the interrupt controller.
// - Latches rising edges of irq_src into pending bits.
// - Holds a 4-bit priority and an enable per source.
// - Scans the sources one per cycle with a single 4-bit compare.
// - Presents the winner to the CPU with a notify / claim / complete handshake.
// Optional feature, enabled by defining INTC_CLAIM_TIMEOUT_EN:
//   a NOTIFY that is not claimed within TIMEOUT cycles is withdrawn, and the
//   block re-arbitrates. Without the macro, NOTIFY waits for claim or for an
//   enable clear.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | nothing presented; waiting for any eligible source
// S_SCAN    | walking idx 0..N_SRC-1, keeping the best eligible source
// S_NOTIFY  | irq_out high, winner presented, waiting for claim
// S_SERVICE | winner claimed (busy); waiting for a matching complete

module intc_prio_arbiter #(
    parameter int N_SRC   = 8,
    parameter int ID_W    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             cfg_we,
    input  logic [ID_W-1:0]  cfg_id,
    input  logic [3:0]       cfg_prio,
    input  logic             cfg_en,
    input  logic [3:0]       threshold,
    input  logic             claim,
    input  logic             complete,
    input  logic [ID_W-1:0]  complete_id,
    output logic             irq_out,
    output logic [ID_W-1:0]  irq_id,
    output logic [3:0]       irq_prio,
    output logic             busy
);

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_SRC - 1);

    if (N_SRC < 2 || N_SRC > 16 || (2 ** ID_W) < N_SRC || TIMEOUT < 1) begin : g_param_check
        $error("intc_prio_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCAN    = 2'd1,
        S_NOTIFY  = 2'd2,
        S_SERVICE = 2'd3
    } state_t;

    state_t             state_q;

    logic [N_SRC-1:0]   src_q;
    logic [N_SRC-1:0]   pending_q;
    logic [N_SRC-1:0]   pending_d;
    logic [N_SRC-1:0]   en_q;
    logic [3:0]         prio_q [N_SRC];

    logic [ID_W-1:0]    idx_q;
    logic [ID_W-1:0]    best_id_q;
    logic [3:0]         best_prio_q;

    logic               irq_out_q;
    logic [ID_W-1:0]    irq_id_q;
    logic [3:0]         irq_prio_q;
    logic               busy_q;

    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   eligible;
    logic               cfg_hit;
    logic               cand;
    logic [3:0]         scan_prio;
    logic [ID_W-1:0]    scan_id;
    logic               scan_last;
    logic               claim_fire;
    logic               done_fire;
    logic               tmo_expire;

    // Rising-edge detect and per-source eligibility from live state.
    always_comb begin
        rise     = irq_src & ~src_q;
        eligible = '0;
        for (int i = 0; i < N_SRC; i++) begin
            eligible[i] = pending_q[i] & en_q[i] & (prio_q[i] > threshold);
        end
    end

    assign cfg_hit = cfg_we && (int'(cfg_id) < N_SRC);

    // One comparator: current scan candidate against the best so far.
    // Strict greater-than, so on a tie the lower index (seen first) keeps the win.
    assign cand      = eligible[idx_q] && (prio_q[idx_q] > best_prio_q);
    assign scan_prio = cand ? prio_q[idx_q] : best_prio_q;
    assign scan_id   = cand ? idx_q : best_id_q;
    assign scan_last = (idx_q == LAST_IDX);

    // A claim only counts while the presented source is still enabled;
    // otherwise NOTIFY is being withdrawn in the same cycle.
    assign claim_fire = (state_q == S_NOTIFY) && en_q[best_id_q] && claim;
    assign done_fire  = (state_q == S_SERVICE) && complete && (complete_id == best_id_q);

    // Pending update: edges set, a claim clears the winner, and an edge in the same cycle wins.
    always_comb begin
        pending_d = pending_q | rise;
        if (claim_fire) begin
            pending_d[best_id_q] = rise[best_id_q];
        end
    end

    // Edge-detect history, pending bits and the priority/enable register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q     <= '0;
            pending_q <= '0;
            en_q      <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                prio_q[i] <= 4'd0;
            end
        end else begin
            src_q     <= irq_src;
            pending_q <= pending_d;
            if (cfg_hit) begin
                prio_q[cfg_id] <= cfg_prio;
                en_q[cfg_id]   <= cfg_en;
            end
        end
    end

`ifdef INTC_CLAIM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] tmo_q;

    // Claim timer: parked at TIMEOUT-1 outside NOTIFY and counting down inside it,
    // so every NOTIFY entry starts a fresh window of TIMEOUT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= CNT_W'(TIMEOUT - 1);
        end else if (state_q != S_NOTIFY) begin
            tmo_q <= CNT_W'(TIMEOUT - 1);
        end else if (tmo_q != '0) begin
            tmo_q <= tmo_q - CNT_W'(1);
        end
    end

    assign tmo_expire = (tmo_q == '0);
`else
    assign tmo_expire = 1'b0;
`endif

    // Arbitration FSM with registered CPU-facing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            best_id_q   <= '0;
            best_prio_q <= 4'd0;
            irq_out_q   <= 1'b0;
            irq_id_q    <= '0;
            irq_prio_q  <= 4'd0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|eligible) begin
                        state_q     <= S_SCAN;
                        idx_q       <= '0;
                        best_id_q   <= '0;
                        best_prio_q <= 4'd0;
                    end
                end

                S_SCAN: begin
                    best_prio_q <= scan_prio;
                    best_id_q   <= scan_id;
                    if (scan_last) begin
                        idx_q <= '0;
                        // Eligible sources have prio > threshold >= 0, so a
                        // non-zero best priority means a winner was found.
                        if (scan_prio != 4'd0) begin
                            state_q    <= S_NOTIFY;
                            irq_out_q  <= 1'b1;
                            irq_id_q   <= scan_id;
                            irq_prio_q <= scan_prio;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        idx_q <= idx_q + ID_W'(1);
                    end
                end

                S_NOTIFY: begin
                    if (!en_q[best_id_q] || (!claim && tmo_expire)) begin
                        // Withdraw: the pending bit is kept for a later scan.
                        state_q    <= S_IDLE;
                        irq_out_q  <= 1'b0;
                        irq_id_q   <= '0;
                        irq_prio_q <= 4'd0;
                    end else if (claim) begin
                        state_q   <= S_SERVICE;
                        irq_out_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                S_SERVICE: begin
                    if (done_fire) begin
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        irq_id_q   <= '0;
                        irq_prio_q <= 4'd0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign irq_out  = irq_out_q;
    assign irq_id   = irq_id_q;
    assign irq_prio = irq_prio_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_intc_prio_arbiter.sv
// Testbench for intc_prio_arbiter: a spec-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_intc_prio_arbiter;

    localparam int N   = 8;
    localparam int IDW = 3;
`ifdef INTC_CLAIM_TIMEOUT_EN
    localparam int TMO    = 4;
    localparam bit TMO_ON = 1'b1;
`else
    localparam int TMO    = 255;
    localparam bit TMO_ON = 1'b0;
`endif

    localparam int PH_IDLE    = 0;
    localparam int PH_SCAN    = 1;
    localparam int PH_PRESENT = 2;
    localparam int PH_SERVE   = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   irq_src;
    logic           cfg_we;
    logic [IDW-1:0] cfg_id;
    logic [3:0]     cfg_prio;
    logic           cfg_en;
    logic [3:0]     threshold;
    logic           claim;
    logic           complete;
    logic [IDW-1:0] complete_id;
    logic           irq_out;
    logic [IDW-1:0] irq_id;
    logic [3:0]     irq_prio;
    logic           busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    intc_prio_arbiter #(
        .N_SRC   (N),
        .ID_W    (IDW),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_src     (irq_src),
        .cfg_we      (cfg_we),
        .cfg_id      (cfg_id),
        .cfg_prio    (cfg_prio),
        .cfg_en      (cfg_en),
        .threshold   (threshold),
        .claim       (claim),
        .complete    (complete),
        .complete_id (complete_id),
        .irq_out     (irq_out),
        .irq_id      (irq_id),
        .irq_prio    (irq_prio),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0]   m_prev, m_pend, m_en;
    logic [3:0]     m_prio [N];
    int             m_phase, m_step, m_tmo;
    logic [3:0]     m_bp;
    logic [IDW-1:0] m_bi;

    always @(posedge clk or posedge rst) begin : model_b
        logic [N-1:0] rise, elig, nxt;
        logic clr;
        if (rst) begin
            m_prev = '0; m_pend = '0; m_en = '0;
            for (int i = 0; i < N; i++) m_prio[i] = 4'd0;
            m_phase = PH_IDLE; m_step = 0; m_tmo = 0; m_bp = 4'd0; m_bi = '0;
        end else begin
            rise = irq_src & ~m_prev;
            clr  = 1'b0;
            for (int i = 0; i < N; i++) elig[i] = m_pend[i] && m_en[i] && (m_prio[i] > threshold);
            case (m_phase)
                PH_IDLE: if (elig != '0) begin
                    m_phase = PH_SCAN; m_step = 0; m_bp = 4'd0; m_bi = '0;
                end
                PH_SCAN: begin
                    if (elig[m_step] && m_prio[m_step] > m_bp) begin
                        m_bp = m_prio[m_step]; m_bi = IDW'(m_step);
                    end
                    if (m_step == N - 1) begin
                        m_phase = (m_bp != 4'd0) ? PH_PRESENT : PH_IDLE;
                        m_tmo   = 0;
                    end else m_step++;
                end
                PH_PRESENT: begin
                    if (!m_en[m_bi]) m_phase = PH_IDLE;
                    else if (claim) begin m_phase = PH_SERVE; clr = 1'b1; end
                    else if (TMO_ON && m_tmo == TMO - 1) m_phase = PH_IDLE;
                    else m_tmo++;
                end
                default: if (complete && complete_id == m_bi) m_phase = PH_IDLE;
            endcase
            nxt = m_pend | rise;
            if (clr && !rise[m_bi]) nxt[m_bi] = 1'b0;
            m_pend = nxt;
            if (cfg_we && int'(cfg_id) < N) begin
                m_prio[cfg_id] = cfg_prio;
                m_en[cfg_id]   = cfg_en;
            end
            m_prev = irq_src;
        end
    end

    // Every-cycle compare of {irq_out, irq_id, irq_prio, busy} against the model.
    always @(negedge clk) begin : cmp_b
        logic [8:0] exp_v;
        if (!rst) begin
            exp_v = {m_phase == PH_PRESENT,
                     (m_phase >= PH_PRESENT) ? m_bi : 3'd0,
                     (m_phase >= PH_PRESENT) ? m_bp : 4'd0,
                     m_phase == PH_SERVE};
            chk("cycle_out_id_prio_busy", {23'd0, irq_out, irq_id, irq_prio, busy}, {23'd0, exp_v});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [IDW-1:0] id, input logic [3:0] pr, input logic en);
        cfg_we = 1'b1; cfg_id = id; cfg_prio = pr; cfg_en = en;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] mask);
        irq_src = mask;
        tick();
        irq_src = '0;
    endtask

    task automatic wait_irq(input int max_cyc);
        int n;
        n = 0;
        while (irq_out !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        chk("wait_irq_out", irq_out, 1);
    endtask

    task automatic serve(input logic [IDW-1:0] id, input logic [3:0] pr);
        wait_irq(40);
        chk("serve_id", irq_id, id);
        chk("serve_prio", irq_prio, pr);
        claim = 1'b1; tick(); claim = 1'b0;
        chk("serve_busy", busy, 1);
        complete_id = id; complete = 1'b1; tick(); complete = 1'b0;
        chk("serve_done", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        rst = 1'b1; irq_src = '0; cfg_we = 1'b0; cfg_id = '0; cfg_prio = 4'd0; cfg_en = 1'b0;
        threshold = 4'd0; claim = 1'b0; complete = 1'b0; complete_id = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_outputs", {irq_out, irq_id, irq_prio, busy}, 9'd0);

        // Latency: pulse in cycle 0, irq_out high exactly 10 cycles later.
        cfg(3'd2, 4'd5, 1'b1);
        irq_src = 8'b0000_0100; tick(); irq_src = '0;
        repeat (8) tick();
        chk("latency_before", irq_out, 0);
        tick();
        chk("latency_out", irq_out, 1);
        chk("latency_id", irq_id, 2);
        chk("latency_prio", irq_prio, 5);
        claim = 1'b1; tick(); claim = 1'b0;
        chk("claim_busy", busy, 1);
        chk("claim_out_low", irq_out, 0);
        chk("claim_id_held", irq_id, 2);
        complete_id = 3'd2; complete = 1'b1; tick(); complete = 1'b0;
        chk("complete_busy", busy, 0);
        repeat (20) tick();
        chk("pending_cleared", irq_out, 0);

        // Tie between 3 and 6 at prio 9 goes to 3; then 6, then 1.
        cfg(3'd1, 4'd7, 1'b1);
        cfg(3'd6, 4'd9, 1'b1);
        cfg(3'd3, 4'd9, 1'b1);
        pulse(8'b0100_1010);
        serve(3'd3, 4'd9);
        serve(3'd6, 4'd9);
        serve(3'd1, 4'd7);

        // Threshold: prio 6 not above threshold 6; qualifies at threshold 5.
        threshold = 4'd6;
        cfg(3'd4, 4'd6, 1'b1);
        pulse(8'b0001_0000);
        repeat (20) tick();
        chk("threshold_block", irq_out, 0);
        threshold = 4'd5;
        serve(3'd4, 4'd6);
        threshold = 4'd0;

        // Enable cleared while presented: withdraw, keep pending, re-present on enable.
        pulse(8'b0000_0100);
        wait_irq(40);
        chk("en_pre_id", irq_id, 2);
        cfg(3'd2, 4'd5, 1'b0);
        chk("en_write_edge", irq_out, 1);
        tick();
        chk("en_drop", irq_out, 0);
        repeat (15) tick();
        chk("en_off_quiet", irq_out, 0);
        cfg(3'd2, 4'd5, 1'b1);
        serve(3'd2, 4'd5);

        // Mismatched complete ignored; edge during service presented afterwards.
        cfg(3'd5, 4'd8, 1'b1);
        pulse(8'b0010_0000);
        wait_irq(40);
        chk("svc_id", irq_id, 5);
        claim = 1'b1; tick(); claim = 1'b0;
        complete_id = 3'd3; complete = 1'b1; tick(); complete = 1'b0;
        chk("bad_complete_busy", busy, 1);
        chk("bad_complete_id", irq_id, 5);
        pulse(8'b0000_0010);
        repeat (12) tick();
        chk("svc_still_busy", busy, 1);
        chk("svc_no_irq", irq_out, 0);
        complete_id = 3'd5; complete = 1'b1; tick(); complete = 1'b0;
        chk("good_complete", busy, 0);
        serve(3'd1, 4'd7);

        // Stray claim / complete while idle are ignored.
        claim = 1'b1; complete = 1'b1; complete_id = 3'd0;
        repeat (3) tick();
        claim = 1'b0; complete = 1'b0;
        chk("stray_busy", busy, 0);
        chk("stray_irq", irq_out, 0);

        // Unclaimed notify: timeout withdraws and re-presents, or holds indefinitely.
        pulse(8'b0000_0100);
        wait_irq(40);
`ifdef INTC_CLAIM_TIMEOUT_EN
        n = 0;
        while (irq_out === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("timeout_len", n, TMO);
        wait_irq(40);
        chk("timeout_repost_id", irq_id, 2);
`else
        n = 0;
        repeat (120) tick();
        chk("no_timeout_hold", irq_out, 1);
        chk("no_timeout_id", irq_id, 2);
`endif
        serve(3'd2, 4'd5);

        // Claim coinciding with a new edge on the winner keeps it pending.
        pulse(8'b0000_0100);
        wait_irq(40);
        irq_src = 8'b0000_0100; claim = 1'b1; tick(); irq_src = '0; claim = 1'b0;
        chk("claim_edge_busy", busy, 1);
        complete_id = 3'd2; complete = 1'b1; tick(); complete = 1'b0;
        serve(3'd2, 4'd5);

        // Asynchronous reset mid-notify clears configuration and outputs.
        pulse(8'b0100_0000);
        wait_irq(40);
        #2 rst = 1'b1;
        #1 chk("async_reset", {irq_out, irq_id, irq_prio, busy}, 9'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        pulse(8'b0100_0000);
        repeat (20) tick();
        chk("post_reset_prio0", irq_out, 0);
        cfg(3'd6, 4'd9, 1'b1);
        serve(3'd6, 4'd9);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/intc_prio_arbiter.md
Name: intc_prio_arbiter

Overview:
- Sequential priority arbiter for the interrupt controller. Latches rising edges on N_SRC interrupt sources into pending bits and holds a 4-bit priority and an enable per source.
- Scans the sources one per cycle using a single 4-bit greater-than compare, then presents the winner to the CPU.
- Runs a notify / claim / complete handshake with the CPU.

Parameters:
- N_SRC, 8, number of interrupt sources (2..16).
- ID_W, 3, width of source index; must satisfy 2^ID_W >= N_SRC.
- TIMEOUT, 255, claim timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- irq_src  in  N_SRC  interrupt sources, synchronous to clk.
- cfg_we  in  1  config write strobe.
- cfg_id  in  ID_W  source index written.
- cfg_prio  in  4  priority written.
- cfg_en  in  1  enable bit written.
- threshold  in  4  global threshold; a source qualifies only if prio > threshold.
- claim  in  1  CPU accepts the presented interrupt.
- complete  in  1  CPU finished servicing.
- complete_id  in  ID_W  id being completed.
- irq_out  out  1  interrupt request to CPU.
- irq_id  out  ID_W  presented or active source id.
- irq_prio  out  4  presented or active priority.
- busy  out  1  a source is in service.

Behaviour:
- Reset:
  - All outputs 0.
  - pending, prio[] and en[] all 0; edge-detect registers 0.
  - State IDLE; scan index 0.
- Edge detect: pending[i] sets on a cycle where irq_src[i]=1 and its previous registered value was 0. The set is visible next cycle.
- Config: cfg_we=1 writes prio[cfg_id] and en[cfg_id] at the clock edge. A write to cfg_id >= N_SRC is ignored.
- Eligibility: eligible[i] = pending[i] & en[i] & (prio[i] > threshold). Priority 0 is never eligible.
- IDLE: if any source is eligible, go to SCAN with idx=0, best_prio=0, best_id=0.
- SCAN (one source per cycle, N_SRC cycles):
  - If eligible[idx] and prio[idx] > best_prio, capture best_id=idx and best_prio=prio[idx].
  - Strict compare: on a tie the lower index wins.
  - Scan evaluates live prio/en/threshold values in each cycle.
  - At idx=N_SRC-1: if a winner was found, go to NOTIFY; otherwise go to IDLE.
- NOTIFY:
  - irq_out=1; irq_id=best_id and irq_prio=best_prio, held stable.
  - If en[best_id] is cleared while in NOTIFY: deassert irq_out next cycle, go to IDLE, pending stays.
  - On claim=1: clear pending[best_id], go to SERVICE, irq_out=0 next cycle.
  - If claim arrives in the same cycle as a new edge on best_id, the set wins and pending stays 1.
- SERVICE:
  - busy=1; irq_id and irq_prio hold the active source.
  - New edges are still latched as pending.
  - complete=1 with complete_id==active id: go to IDLE, busy=0 next cycle.
  - A mismatched complete_id is ignored.
- claim outside NOTIFY and complete outside SERVICE are ignored.
- Latency: an edge at cycle t sets pending at t+1; IDLE exits at t+1 → SCAN t+2..t+1+N_SRC → irq_out=1 at t+2+N_SRC.
- Reset asserted mid-operation clears all state immediately; edges in flight are lost.

Optional Feature:
- Macro: INTC_CLAIM_TIMEOUT_EN.
- Defined:
  - A counter runs in NOTIFY.
  - If claim is not seen within TIMEOUT cycles of entering NOTIFY, irq_out deasserts, pending is kept, and the block returns to IDLE to re-arbitrate.
  - The counter clears on every NOTIFY entry.
- Undefined: no counter; NOTIFY waits indefinitely for claim or an enable clear.

Test Plan:
- Reset, then threshold=0, prio[2]=5 en=1, pulse irq_src[2] → irq_out=1, irq_id=2, irq_prio=5 exactly 10 cycles after the pulse (N_SRC=8). claim → pending[2]=0, busy=1. complete with id 2 → busy=0, IDLE.
- prio[1]=7, prio[6]=9, prio[3]=9; pulse sources 1, 3 and 6 together → irq_id=3 (tie resolved to the lower index).
- threshold=6, prio[4]=6, pulse source 4 → irq_out stays 0. Then write threshold=5 → irq_out=1, id 4.
- In NOTIFY for id 2, write en[2]=0 → irq_out=0 next cycle, pending[2] still 1. Re-enable → re-presented.
- In SERVICE for id 5, send complete with complete_id=3 → still busy. A new edge on source 1 latches pending[1], which is presented after a correct complete for id 5.
- With INTC_CLAIM_TIMEOUT_EN and TIMEOUT=4, no claim → irq_out drops after 4 cycles in NOTIFY and re-asserts after a rescan. Without the macro → irq_out stays high for more than 100 cycles.
